// File: rtl/i2c_byte_master_pkg.sv
// Shared types and register map for the I2C byte master: FSM states,
// Avalon register addresses and CMD/STATUS bit positions.
package i2c_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_ACK   = 3'd3,
        ST_STOP  = 3'd4
    } state_t;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_CMD     = 2'd1;
    localparam logic [1:0] ADDR_STATUS  = 2'd2;
    localparam logic [1:0] ADDR_DIVIDER = 2'd3;

    localparam int CMD_START   = 0;
    localparam int CMD_STOP    = 1;
    localparam int CMD_WRITE   = 2;
    localparam int CMD_READ    = 3;
    localparam int CMD_ACK_OUT = 4;

    localparam int STAT_BUSY   = 0;
    localparam int STAT_RX_ACK = 1;

endpackage

// File: rtl/i2c_byte_master_if.sv
// Avalon-MM register port plus open-drain pad controls of the I2C byte master.
// The engine uses the slave modport; the host side (CPU/bench) uses master.
interface i2c_byte_master_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        scl_in;
    logic        sda_in;
    logic        scl_oe;
    logic        sda_oe;

    modport slave (
        input  address, chipselect, write_n, writedata, scl_in, sda_in,
        output readdata, scl_oe, sda_oe
    );

    modport master (
        output address, chipselect, write_n, writedata, scl_in, sda_in,
        input  readdata, scl_oe, sda_oe
    );

endinterface

// File: rtl/i2c_byte_master_tick_gen.sv
// Quarter-bit tick generator: counts 0..divider and pulses on the last count.
module i2c_tick_gen (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] i_divider,
    input  logic        i_restart,
    input  logic        i_hold,
    output logic        o_tick
);

    logic [15:0] r_count;

    // A held (stretched) quarter restarts its full length once SCL is seen high.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= 16'd0;
        end else if (i_restart || i_hold || (r_count >= i_divider)) begin
            r_count <= 16'd0;
        end else begin
            r_count <= r_count + 16'd1;
        end
    end

    assign o_tick = (r_count == i_divider) && !i_hold && !i_restart;

endmodule

// File: rtl/i2c_byte_master.sv
// Hardware I2C master byte engine (START / byte WRITE or READ + ACK / STOP).
// Define I2C_CLOCK_STRETCH_EN to let a slave stretch any released-SCL phase.
module i2c_byte_master
    import i2c_master_pkg::*;
#(
    parameter logic [15:0] DIV_RESET = 16'd124
) (
    input  logic               clk,
    input  logic               reset,
    i2c_byte_master_if.slave   bus
);

    logic [7:0]  r_tx;
    logic [7:0]  r_rx;
    logic [15:0] r_divider;
    logic        r_busy;
    logic        r_rxAck;
    state_t      r_state;
    logic [1:0]  r_phase;
    logic [2:0]  r_bitCnt;
    logic        r_doData;
    logic        r_isWrite;
    logic        r_doStop;
    logic        r_ackOut;
    logic        r_busHeld;
    logic [31:0] r_readdata;

    logic        w_write;
    logic        w_cmdAccept;
    logic        w_tick;
    logic        w_hold;
    logic        w_sclOe;
    logic        w_sdaOe;
    state_t      w_nextState;

    assign w_write     = bus.chipselect && !bus.write_n && !r_busy;
    assign w_cmdAccept = w_write && (bus.address == ADDR_CMD) && (bus.writedata[3:0] != 4'd0);

`ifdef I2C_CLOCK_STRETCH_EN
    assign w_hold = r_busy && !w_sclOe && !bus.scl_in;
`else
    assign w_hold = 1'b0;
`endif

    i2c_tick_gen u_tickGen (
        .clk       (clk),
        .reset     (reset),
        .i_divider (r_divider),
        .i_restart (w_cmdAccept),
        .i_hold    (w_hold),
        .o_tick    (w_tick)
    );

    // Where the sequence goes when the current state's fourth quarter ends.
    always_comb begin
        w_nextState = ST_IDLE;
        case (r_state)
            ST_START: w_nextState = r_doData ? ST_DATA : (r_doStop ? ST_STOP : ST_IDLE);
            ST_DATA:  w_nextState = (r_bitCnt == 3'd0) ? ST_ACK : ST_DATA;
            ST_ACK:   w_nextState = r_doStop ? ST_STOP : ST_IDLE;
            default:  w_nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx      <= 8'd0;
            r_rx      <= 8'd0;
            r_divider <= DIV_RESET;
            r_busy    <= 1'b0;
            r_rxAck   <= 1'b0;
            r_state   <= ST_IDLE;
            r_phase   <= 2'd0;
            r_bitCnt  <= 3'd7;
            r_doData  <= 1'b0;
            r_isWrite <= 1'b0;
            r_doStop  <= 1'b0;
            r_ackOut  <= 1'b0;
            r_busHeld <= 1'b0;
        end else begin
            if (w_write && (bus.address == ADDR_DATA))
                r_tx <= bus.writedata[7:0];
            if (w_write && (bus.address == ADDR_DIVIDER))
                r_divider <= bus.writedata[15:0];

            if (w_cmdAccept) begin
                r_busy    <= 1'b1;
                r_phase   <= 2'd0;
                r_bitCnt  <= 3'd7;
                r_doData  <= bus.writedata[CMD_WRITE] | bus.writedata[CMD_READ];
                r_isWrite <= bus.writedata[CMD_WRITE];
                r_doStop  <= bus.writedata[CMD_STOP];
                r_ackOut  <= bus.writedata[CMD_ACK_OUT];
                if (bus.writedata[CMD_START])
                    r_state <= ST_START;
                else if (bus.writedata[CMD_WRITE] | bus.writedata[CMD_READ])
                    r_state <= ST_DATA;
                else
                    r_state <= ST_STOP;
            end else if (r_busy && w_tick) begin
                r_phase <= r_phase + 2'd1;
                // SDA is sampled on the tick that closes the second SCL-high quarter.
                if (r_phase == 2'd2) begin
                    if ((r_state == ST_DATA) && !r_isWrite)
                        r_rx <= {r_rx[6:0], bus.sda_in};
                    if ((r_state == ST_ACK) && r_isWrite)
                        r_rxAck <= bus.sda_in;
                end
                if (r_phase == 2'd3) begin
                    r_state <= w_nextState;
                    if (r_state == ST_DATA)
                        r_bitCnt <= r_bitCnt - 3'd1;
                    if (w_nextState == ST_IDLE) begin
                        r_busy    <= 1'b0;
                        r_busHeld <= (r_state != ST_STOP);
                    end
                end
            end
        end
    end

    // Pad drive (1 = pull low). A bus left without STOP keeps SCL low.
    always_comb begin
        w_sclOe = 1'b0;
        w_sdaOe = 1'b0;
        case (r_state)
            ST_IDLE: w_sclOe = r_busHeld;
            ST_START: begin
                w_sdaOe = r_phase[1];
                w_sclOe = (r_phase == 2'd3);
            end
            ST_DATA: begin
                w_sclOe = (r_phase == 2'd0) || (r_phase == 2'd3);
                w_sdaOe = r_isWrite && !r_tx[r_bitCnt];
            end
            ST_ACK: begin
                w_sclOe = (r_phase == 2'd0) || (r_phase == 2'd3);
                w_sdaOe = !r_isWrite && !r_ackOut;
            end
            ST_STOP: begin
                w_sdaOe = (r_phase != 2'd3);
                w_sclOe = (r_phase == 2'd0);
            end
            default: begin
                w_sclOe = 1'b0;
                w_sdaOe = 1'b0;
            end
        endcase
    end

    assign bus.scl_oe = w_sclOe;
    assign bus.sda_oe = w_sdaOe;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_readdata <= 32'd0;
        end else begin
            case (bus.address)
                ADDR_DATA:    r_readdata <= {24'd0, r_rx};
                ADDR_STATUS:  r_readdata <= {30'd0, r_rxAck, r_busy};
                ADDR_DIVIDER: r_readdata <= {16'd0, r_divider};
                default:      r_readdata <= 32'd0;
            endcase
        end
    end

    assign bus.readdata = r_readdata;

endmodule
